spiker_reader: RTL and testbench

//  Input-side counterpart of the result path. On a software start, copies the N_REG

---
 rtl/spiker_adapter_pkg.sv | 15 +
 rtl/spiker_reader_if.sv | 30 +++
 rtl/spiker_reader_watchdog.sv | 30 +++
 rtl/spiker_reader.sv | 160 ++++++++++++++++
 tb/tb_spiker_reader.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spiker_adapter_pkg.sv
// Shared geometry and reader state type for the spiker input/result adapters.
package spiker_adapter_pkg;

    localparam int unsigned SPK_WIDTH    = 32;
    localparam int unsigned SPK_N_REG    = 25;
    localparam int unsigned SPK_N_SPIKES = 784;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_LOAD,
        RD_PRESENT,
        RD_WAIT_RES
    } spiker_rd_state_e;

endpackage

// File: rtl/spiker_reader_if.sv
// Reader <-> neural core link: spike vector handshake plus result capture strobe.
interface spiker_reader_if
    import spiker_adapter_pkg::*;
#(
    parameter int unsigned N_SPIKES = SPK_N_SPIKES
);

    logic [N_SPIKES-1:0] data_in_o;
    logic                valid_o;
    logic                ready_i;
    logic                core_done_i;
    logic                sample_o;

    modport master (
        output data_in_o,
        output valid_o,
        output sample_o,
        input  ready_i,
        input  core_done_i
    );

    modport slave (
        input  data_in_o,
        input  valid_o,
        input  sample_o,
        output ready_i,
        output core_done_i
    );

endinterface

// File: rtl/spiker_reader_watchdog.sv
// Cycle watchdog: counts while run_i is high, restarts on clr_i, flags the last cycle.
module spiker_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic run_i,
    input  logic clr_i,
    output logic expired_o
);

    localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q;

    // Count cycles spent in the current supervised state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (!run_i || clr_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expired_o = run_i && (cnt_q == LIMIT);

endmodule

// File: rtl/spiker_reader.sv
// Spiker reader: snapshots the input-spike CSR words, presents them to the core
// with valid/ready, waits for core completion and pulses sample_o/done_o.
// Optional watchdog abort is enabled by defining SPIKER_READER_TIMEOUT_EN.
module spiker_reader
    import spiker_adapter_pkg::*;
#(
    parameter int unsigned WIDTH          = SPK_WIDTH,
    parameter int unsigned N_SPIKES       = SPK_N_SPIKES,
    parameter int unsigned N_REG          = SPK_N_REG,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [N_REG*WIDTH-1:0] spikes_i,
    input  logic                   start_i,
    input  logic                   err_clr_i,
    spiker_reader_if.master        core_if,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   overrun_o,
    output logic                   timeout_o
);

    localparam int unsigned CNT_W = (N_REG > 1) ? $clog2(N_REG) : 1;
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(N_REG - 1);

    spiker_rd_state_e       state_q, state_d;
    logic [CNT_W-1:0]       word_cnt_q, word_cnt_d;
    logic [N_REG*WIDTH-1:0] shadow_q;
    logic                   load_en;
    logic                   done_q, done_d;
    logic                   overrun_q, overrun_d;
    logic                   timeout_q, timeout_d;
    logic                   wd_expired;

`ifdef SPIKER_READER_TIMEOUT_EN
    logic wd_run;
    assign wd_run = (state_q == RD_PRESENT) || (state_q == RD_WAIT_RES);

    spiker_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .run_i    (wd_run),
        .clr_i    (state_d != state_q),
        .expired_o(wd_expired)
    );
`else
    localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
    assign wd_expired = 1'b0;
`endif

    // Next-state, word counter, completion pulse and sticky error flags.
    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        load_en    = 1'b0;
        done_d     = 1'b0;
        overrun_d  = overrun_q;
        timeout_d  = timeout_q;

        case (state_q)
            RD_IDLE: begin
                // The completion cycle still counts as busy for a new start.
                if (start_i && !done_q) begin
                    state_d    = RD_LOAD;
                    word_cnt_d = '0;
                end
            end
            RD_LOAD: begin
                load_en = 1'b1;
                if (word_cnt_q == LAST_WORD) begin
                    state_d = RD_PRESENT;
                end else begin
                    word_cnt_d = word_cnt_q + 1'b1;
                end
            end
            RD_PRESENT: begin
                if (ready_accept()) begin
                    state_d = RD_WAIT_RES;
                end
                if (wd_expired) begin
                    state_d   = RD_IDLE;
                    timeout_d = 1'b1;
                end
            end
            RD_WAIT_RES: begin
                // A completion arriving on the watchdog's last cycle still wins.
                if (core_if.core_done_i) begin
                    state_d = RD_IDLE;
                    done_d  = 1'b1;
                end else if (wd_expired) begin
                    state_d   = RD_IDLE;
                    timeout_d = 1'b1;
                end
            end
            default: state_d = RD_IDLE;
        endcase

        if (err_clr_i) begin
            overrun_d = 1'b0;
            if (!(wd_expired && (state_d == RD_IDLE) && !done_d &&
                  (state_q == RD_PRESENT || state_q == RD_WAIT_RES))) begin
                timeout_d = 1'b0;
            end
        end
        if (start_i && ((state_q != RD_IDLE) || done_q)) begin
            overrun_d = 1'b1;
        end
    end

    function automatic logic ready_accept();
        return core_if.ready_i;
    endfunction

    // State, counter and status registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= RD_IDLE;
            word_cnt_q <= '0;
            done_q     <= 1'b0;
            overrun_q  <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            done_q     <= done_d;
            overrun_q  <= overrun_d;
            timeout_q  <= timeout_d;
        end
    end

    // Shadow buffer: copy the CSR word selected by the word counter during LOAD.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shadow_q <= '0;
        end else if (load_en) begin
            for (int unsigned i = 0; i < N_REG; i++) begin
                if (word_cnt_q == CNT_W'(i)) begin
                    shadow_q[i*WIDTH +: WIDTH] <= spikes_i[i*WIDTH +: WIDTH];
                end
            end
        end
    end

    if (N_REG * WIDTH > N_SPIKES) begin : g_shadow_pad
        logic unused_shadow_hi;
        assign unused_shadow_hi = ^shadow_q[N_REG*WIDTH-1:N_SPIKES];
    end

    assign core_if.data_in_o = shadow_q[N_SPIKES-1:0];
    assign core_if.valid_o   = (state_q == RD_PRESENT);
    assign core_if.sample_o  = done_q;
    assign busy_o            = (state_q != RD_IDLE);
    assign done_o            = done_q;
    assign overrun_o         = overrun_q;
    assign timeout_o         = timeout_q;

endmodule

// File: tb/tb_spiker_reader.sv
module tb_spiker_reader;
    import spiker_adapter_pkg::*;

    localparam int unsigned W      = SPK_WIDTH;
    localparam int unsigned NR     = SPK_N_REG;
    localparam int unsigned NS     = SPK_N_SPIKES;
    localparam int unsigned TO_CYC = 16;
`ifdef SPIKER_READER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NR*W-1:0] spikes;
    logic            start, err_clr;
    logic            busy, done, ovr, tmo;

    spiker_reader_if #(.N_SPIKES(NS)) core_if ();

    spiker_reader #(
        .WIDTH(W), .N_SPIKES(NS), .N_REG(NR), .TIMEOUT_CYCLES(TO_CYC)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .spikes_i(spikes), .start_i(start),
        .err_clr_i(err_clr), .core_if(core_if.master), .busy_o(busy),
        .done_o(done), .overrun_o(ovr), .timeout_o(tmo)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [NS-1:0] act, input logic [NS-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Transaction timeline: age counts cycles since an accepted start; words are
    // captured at ages 1..NR, presentation starts at age NR+1.
    bit          m_active, m_hs, m_sample, m_ovr, m_to;
    int          m_age, m_ph;
    logic [W-1:0] m_shadow [NR];

    function automatic logic [NS-1:0] m_data();
        logic [NR*W-1:0] v;
        for (int i = 0; i < NR; i++) v[i*W +: W] = m_shadow[i];
        return v[NS-1:0];
    endfunction

    function automatic bit m_valid();
        return m_active && (m_age == NR + 1) && !m_hs;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 0; m_hs = 0; m_sample = 0; m_ovr = 0; m_to = 0;
            m_age = 0; m_ph = 0;
            for (int i = 0; i < NR; i++) m_shadow[i] = '0;
        end else begin
            bit busy_start, new_sample, to_set;
            busy_start = start && (m_active || m_sample);
            new_sample = 0;
            to_set = 0;
            if (m_active) begin
                if (m_age <= NR) begin
                    m_shadow[m_age-1] = spikes[(m_age-1)*W +: W];
                    m_age++;
                    m_ph = 0;
                end else if (!m_hs) begin
                    if (TO_EN && m_ph == TO_CYC - 1) begin m_active = 0; to_set = 1; end
                    else if (core_if.ready_i) begin m_hs = 1; m_ph = 0; end
                    else m_ph++;
                end else begin
                    if (core_if.core_done_i) begin m_active = 0; new_sample = 1; end
                    else if (TO_EN && m_ph == TO_CYC - 1) begin m_active = 0; to_set = 1; end
                    else m_ph++;
                end
            end else if (start && !m_sample) begin
                m_active = 1; m_age = 1; m_hs = 0;
            end
            m_sample = new_sample;
            if (busy_start) m_ovr = 1; else if (err_clr) m_ovr = 0;
            if (to_set) m_to = 1; else if (err_clr) m_to = 0;
        end
    end

    // ---------------- compare process ----------------
    int sample_cnt = 0;
    int hs_cnt = 0;

    always @(negedge clk) begin
        chk("busy", NS'(busy), NS'(m_active));
        chk("valid", NS'(core_if.valid_o), NS'(m_valid()));
        chk("sample", NS'(core_if.sample_o), NS'(m_sample));
        chk("done", NS'(done), NS'(m_sample));
        chk("overrun", NS'(ovr), NS'(m_ovr));
        chk("timeout", NS'(tmo), NS'(m_to));
        if (m_valid()) chk("data_in", core_if.data_in_o, m_data());
        if (core_if.sample_o) sample_cnt++;
    end

    always @(posedge clk) if (core_if.valid_o && core_if.ready_i) hs_cnt++;

    // ---------------- stimulus ----------------
    task automatic start_wait_valid(output int lat);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (!core_if.valid_o && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic pulse_done();
        core_if.core_done_i = 1'b1;
        @(negedge clk);
        core_if.core_done_i = 1'b0;
    endtask

    initial begin
        #1_000_000;
        failures++;
        $display("FAIL global_timeout: got stuck expected finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "time limit");
    end

    initial begin
        int lat, vcnt, s0;
        logic [NS-1:0] d;
        spikes = '0; start = 0; err_clr = 0;
        core_if.ready_i = 0; core_if.core_done_i = 0;
        repeat (3) @(negedge clk);
        chk("reset_busy", NS'(busy), '0);
        chk("reset_data", core_if.data_in_o, '0);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // 1 + 3: basic transfer, latency, word layout, one handshake, done pulse
        for (int i = 0; i < NR; i++) spikes[i*W +: W] = 32'hA500_0000 | i;
        core_if.ready_i = 1'b1;
        hs_cnt = 0; sample_cnt = 0;
        start_wait_valid(lat);
        chk("t1_latency", NS'(lat), NS'(26));
        d = core_if.data_in_o;
        chk("t1_word0", NS'(d[31:0]), NS'(32'hA500_0000));
        chk("t1_top16", NS'(d[783:768]), NS'(16'h0018));
        repeat (10) @(negedge clk);
        chk("t1_hs_count", NS'(hs_cnt), NS'(1));
        chk("t3_busy_wait", NS'(busy), NS'(1));
        pulse_done();
        chk("t3_done", NS'(done), NS'(1));
        chk("t3_sample", NS'(core_if.sample_o), NS'(1));
        @(negedge clk);
        chk("t3_busy_after", NS'(busy), NS'(0));
        chk("t3_done_after", NS'(done), NS'(0));
        @(negedge clk);
        chk("t3_sample_count", NS'(sample_cnt), NS'(1));

        // 2: backpressure
        for (int i = 0; i < NR; i++) spikes[i*W +: W] = 32'h5A5A_0000 ^ (i * 32'h0101_0101);
        core_if.ready_i = 1'b0;
        start_wait_valid(lat);
        chk("t2_latency", NS'(lat), NS'(26));
        vcnt = 0;
        repeat (50) begin
            @(negedge clk);
            if (core_if.valid_o) vcnt++;
        end
        chk("t2_valid_held", NS'(vcnt), NS'(50));
        d = core_if.data_in_o;
        chk("t2_word1", NS'(d[63:32]), NS'(32'h5B5B_0101));
        core_if.ready_i = 1'b1;
        @(negedge clk);
        core_if.ready_i = 1'b0;
        chk("t2_valid_drop", NS'(core_if.valid_o), NS'(0));
        chk("t2_wait_busy", NS'(busy), NS'(1));
        repeat (3) @(negedge clk);
        pulse_done();
        @(negedge clk);

        // 4: overrun handling
        core_if.ready_i = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("t4_ovr_load", NS'(ovr), NS'(1));
        lat = 0;
        while (!core_if.valid_o && lat < 200) begin @(negedge clk); lat++; end
        repeat (3) @(negedge clk);
        chk("t4_flow_wait", NS'(busy), NS'(1));
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("t4_ovr_clr", NS'(ovr), NS'(0));
        start = 1'b1; err_clr = 1'b1;
        @(negedge clk);
        start = 1'b0; err_clr = 1'b0;
        chk("t4_set_wins", NS'(ovr), NS'(1));
        chk("t4_still_busy", NS'(busy), NS'(1));
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        s0 = sample_cnt;
        pulse_done();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("t4_ovr_done_cycle", NS'(ovr), NS'(1));
        chk("t4_no_restart", NS'(busy), NS'(0));
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;

        // 5: late CSR write and reset mid-PRESENT
        for (int i = 0; i < NR; i++) spikes[i*W +: W] = 32'h1000_0000 + i;
        core_if.ready_i = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        spikes[3*W +: W]  = 32'hDEAD_0003;
        spikes[20*W +: W] = 32'hBEEF_0014;
        lat = 0;
        while (!core_if.valid_o && lat < 200) begin @(negedge clk); lat++; end
        d = core_if.data_in_o;
        chk("t5_word3_old", NS'(d[127:96]), NS'(32'h1000_0003));
        chk("t5_word20_new", NS'(d[20*W +: W]), NS'(32'hBEEF_0014));
        repeat (4) @(negedge clk);
        s0 = sample_cnt;
        #2 rst_n = 1'b0;
        core_if.core_done_i = 1'b1;
        @(negedge clk);
        core_if.core_done_i = 1'b0;
        chk("t5_rst_valid", NS'(core_if.valid_o), '0);
        chk("t5_rst_busy", NS'(busy), '0);
        chk("t5_rst_data", core_if.data_in_o, '0);
        #2 rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("t5_no_sample", NS'(sample_cnt), NS'(s0));

        // 6: watchdog behaviour
        core_if.ready_i = 1'b0;
        start_wait_valid(lat);
`ifdef SPIKER_READER_TIMEOUT_EN
        s0 = sample_cnt;
        repeat (TO_CYC) @(negedge clk);
        chk("t6_timeout", NS'(tmo), NS'(1));
        chk("t6_busy", NS'(busy), NS'(0));
        repeat (3) @(negedge clk);
        chk("t6_no_sample", NS'(sample_cnt), NS'(s0));
`else
        vcnt = 0;
        repeat (10000) begin
            @(negedge clk);
            if (core_if.valid_o) vcnt++;
        end
        chk("t6_valid_held", NS'(vcnt), NS'(10000));
        chk("t6_timeout_off", NS'(tmo), NS'(0));
        core_if.ready_i = 1'b1;
        @(negedge clk);
        core_if.ready_i = 1'b0;
        repeat (2) @(negedge clk);
        pulse_done();
        @(negedge clk);
`endif
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
